// File: rtl/conv_filter_nxn.sv
// conv_filter_nxn: streaming K x K convolution over a raster pixel stream.
// K-1 line buffers feed a K x K window. Out-of-frame taps are masked to zero
// from the output position, so stale line-buffer contents never leak through.
// Optional feature: define CONV_SAT_COUNT_EN to add the sat_count port.
module conv_filter_nxn #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int K          = 3,
    parameter int W          = 8,
    parameter int SHIFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [W-1:0]     x_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [W-1:0]     y_data,
    input  logic [K*K*W-1:0] kernel,
    input  logic [1:0]       out_mode
`ifdef CONV_SAT_COUNT_EN
    ,
    output logic [15:0]      sat_count
`endif
);

    localparam int R      = (K - 1) / 2;
    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int FILL_N = R * IMG_WIDTH + R;
    localparam int AW     = 2 * W + 1 + $clog2(K * K);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int PW     = $clog2(NPIX);
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** W) - 1);
    localparam logic signed [AW-1:0] BIAS = AW'(2 ** (W - 1));

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] in_cnt;
    logic [CW-1:0] pc;          // column of the next pushed pixel
    logic [RW-1:0] ro;          // position of the next produced output
    logic [CW-1:0] co;
    logic [W-1:0]  lb      [K-1][IMG_WIDTH];
    logic [W-1:0]  win     [K][K];
    logic [W-1:0]  win_nxt [K][K];
    logic [W-1:0]  colv    [K];
    logic [W-1:0]  pix;
    logic          accept, flush_push, push, produce, last_out, frame_done;
    logic signed [AW-1:0] acc, shf, md;
    logic [W-1:0]  res;
    logic          sat;

    assign accept     = x_valid && x_ready;
    assign flush_push = (state == FLUSH) && (!y_valid || y_ready);
    assign push       = accept || flush_push;
    assign produce    = push && (state != FILL);
    assign pix        = (state == FLUSH) ? '0 : x_data;
    assign last_out   = (ro == RW'(IMG_HEIGHT - 1)) && (co == CW'(IMG_WIDTH - 1));
    assign frame_done = flush_push && last_out;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && in_cnt == PW'(FILL_N - 1)) state_nxt = RUN;
            RUN:     if (accept && in_cnt == PW'(NPIX - 1))   state_nxt = FLUSH;
            FLUSH:   if (frame_done)                          state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Output decode: input readiness per state, held low during reset
    always_comb begin
        x_ready = 1'b0;
        case (state)
            FILL:    x_ready = rst_n;
            RUN:     x_ready = rst_n && (!y_valid || y_ready);
            default: x_ready = 1'b0;
        endcase
    end

    // Window as it will look after the current push
    always_comb begin
        colv[K-1] = pix;
        for (int unsigned i = 0; i < K - 1; i++) colv[i] = lb[K-2-i][pc];
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                win_nxt[i][j] = (j < K - 1) ? win[i][j+1] : colv[i];
            end
        end
    end

    // Masked multiply-accumulate, shift, mode operation and clamp
    always_comb begin : mac
        int rr, cc;
        logic signed [W:0]     px_s;
        logic signed [W-1:0]   cf;
        logic signed [2*W:0]   prod;
        rr = 0; cc = 0; px_s = '0; cf = '0; prod = '0;
        acc = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                rr   = int'(ro) + int'(i) - R;
                cc   = int'(co) + int'(j) - R;
                px_s = {1'b0, win_nxt[i][j]};
                cf   = kernel[(i*K+j)*W +: W];
                prod = px_s * cf;
                if (rr >= 0 && rr < IMG_HEIGHT && cc >= 0 && cc < IMG_WIDTH)
                    acc = acc + {{(AW-2*W-1){prod[2*W]}}, prod};
            end
        end
        shf = acc >>> SHIFT;
        case (out_mode)
            2'b01:   md = (shf < 0) ? -shf : shf;
            2'b10:   md = shf + BIAS;
            default: md = shf;
        endcase
        sat = 1'b1;
        if (md < 0)         res = '0;
        else if (md > MAXV) res = '1;
        else begin
            res = md[W-1:0];
            sat = 1'b0;
        end
    end

    // Counters, window register and registered output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            pc      <= '0;
            ro      <= '0;
            co      <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
            for (int unsigned i = 0; i < K; i++)
                for (int unsigned j = 0; j < K; j++) win[i][j] <= '0;
        end else begin
            if (push) begin
                win <= win_nxt;
                pc  <= (pc == CW'(IMG_WIDTH - 1)) ? '0 : pc + CW'(1);
            end
            if (accept) in_cnt <= in_cnt + PW'(1);
            if (produce) begin
                y_valid <= 1'b1;
                y_data  <= res;
                if (co == CW'(IMG_WIDTH - 1)) begin
                    co <= '0;
                    ro <= (ro == RW'(IMG_HEIGHT - 1)) ? '0 : ro + RW'(1);
                end else begin
                    co <= co + CW'(1);
                end
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
            if (frame_done) begin
                in_cnt <= '0;
                pc     <= '0;
                ro     <= '0;
                co     <= '0;
            end
        end
    end

    // Line buffers: each push shifts the column down by one line
    always_ff @(posedge clk) begin
        if (push) begin
            lb[0][pc] <= pix;
            for (int unsigned k = 1; k < K - 1; k++) lb[k][pc] <= lb[k-1][pc];
        end
    end

`ifdef CONV_SAT_COUNT_EN
    logic sat_clr_pend;

    // Saturation counter: the end-of-frame clear is deferred to the first
    // output of the next frame so the final count stays readable meanwhile
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count    <= '0;
            sat_clr_pend <= 1'b0;
        end else begin
            if (produce) begin
                if (sat_clr_pend)
                    sat_count <= {15'd0, sat};
                else if (sat && sat_count != 16'hFFFF)
                    sat_count <= sat_count + 16'd1;
            end
            if (frame_done)   sat_clr_pend <= 1'b1;
            else if (produce) sat_clr_pend <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_conv_filter_nxn.sv
// tb_conv_filter_nxn: directed and randomized frames against a direct 2-D
// zero-padded convolution model of the expected output image.
module tb_conv_filter_nxn;

    localparam int IW = 8, IH = 6, K = 3, W = 8, SHIFT = 0, NP = IW * IH;

    logic clk = 1'b0, rst_n = 1'b0, x_valid = 1'b0, y_ready = 1'b0;
    logic x_ready, y_valid;
    logic [W-1:0] x_data = '0, y_data;
    logic [K*K*W-1:0] kernel = '0;
    logic [1:0] out_mode = 2'b00;
`ifdef CONV_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    conv_filter_nxn #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .K(K), .W(W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .kernel(kernel), .out_mode(out_mode)
`ifdef CONV_SAT_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int pix [NP];
    int coef [K][K];
    logic [W-1:0] out_q [$];
    int cyc = 0;
    int first_valid_cyc = -1;
    int acc9_cyc = -1;
    int stall_mode = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: collects handshakes and checks stability while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(y_valid), 32'd1);
                chk("stall_data", 32'(y_data), 32'(prev_data));
            end
            if (y_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (y_valid && y_ready) out_q.push_back(y_data);
            prev_stall = y_valid && !y_ready;
            prev_data  = y_data;
        end
    end

    function automatic logic policy();
        case (stall_mode)
            0:       return 1'b1;
            1:       return cyc[0];
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    function automatic int ref_out(int r, int c);
        int a = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
                int rr = r + i - (K - 1) / 2;
                int cc = c + j - (K - 1) / 2;
                if (rr >= 0 && rr < IH && cc >= 0 && cc < IW)
                    a += pix[rr * IW + cc] * coef[i][j];
            end
        a = a >>> SHIFT;
        if (out_mode == 2'b01 && a < 0) a = -a;
        if (out_mode == 2'b10) a += 128;
        if (a < 0) a = 0;
        if (a > 255) a = 255;
        return a;
    endfunction

    task automatic pack_kernel();
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                kernel[(i*K+j)*W +: W] = W'(coef[i][j]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_ready", 32'(x_ready), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_y_valid", 32'(y_valid), 32'd0);
        out_q.delete();
    endtask

    // Presents pixels 0..n-1 one by one; entry/exit at posedge+1
    task automatic send_pixels(input int n);
        for (int idx = 0; idx < n; idx++) begin
            int tries = 0;
            logic done = 1'b0;
            x_valid = 1'b1;
            x_data  = W'(pix[idx]);
            while (!done && tries < 200) begin
                y_ready = policy();
                #1;
                done = x_ready;
                @(posedge clk); #1;
                tries++;
                if (done && idx == 9) acc9_cyc = cyc;
            end
            if (!done) begin
                chk("accept_timeout", 32'd0, 32'd1);
                x_valid = 1'b0;
                return;
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        int t = 0;
        out_q.delete();
        first_valid_cyc = -1;
        acc9_cyc = -1;
        pack_kernel();
        send_pixels(NP);
        while (out_q.size() < NP && t < 1000) begin
            y_ready = policy();
            @(posedge clk); #1;
            t++;
        end
        y_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(out_q.size()), 32'(NP));
        for (int k = 0; k < NP && k < out_q.size(); k++)
            chk($sformatf("%s_px%0d", tag, k), 32'(out_q[k]), 32'(ref_out(k / IW, k % IW)));
    endtask

    task automatic set_identity();
        for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) coef[i][j] = 0;
        coef[1][1] = 1;
    endtask

    task automatic set_box();
        for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) coef[i][j] = 1;
    endtask

    initial begin
        do_reset();

        // Identity kernel on a ramp
        set_identity(); out_mode = 2'b00; stall_mode = 0;
        for (int k = 0; k < NP; k++) pix[k] = k;
        run_frame("ident");
        chk("ident_last", 32'(out_q[NP-1]), 32'd47);

        // Box kernel on constant 10, plus first-output latency
        set_box();
        for (int k = 0; k < NP; k++) pix[k] = 10;
        run_frame("box10");
        chk("box10_corner", 32'(out_q[0]), 32'd40);
        chk("box10_edge", 32'(out_q[3]), 32'd60);
        chk("box10_inner", 32'(out_q[10]), 32'd90);
        chk("box10_latency", 32'(first_valid_cyc), 32'(acc9_cyc));

        // Sobel-Y on a horizontal step, modes 01 and 00
        coef[0][0] = -1; coef[0][1] = -2; coef[0][2] = -1;
        coef[1][0] = 0;  coef[1][1] = 0;  coef[1][2] = 0;
        coef[2][0] = 1;  coef[2][1] = 2;  coef[2][2] = 1;
        for (int k = 0; k < NP; k++) pix[k] = (k / IW < 3) ? 0 : 100;
        out_mode = 2'b01;
        run_frame("sobel_abs");
        chk("sobel_abs_r2", 32'(out_q[2*IW+3]), 32'd255);
        chk("sobel_abs_r3", 32'(out_q[3*IW+4]), 32'd255);
        chk("sobel_abs_r1", 32'(out_q[1*IW+3]), 32'd0);
        chk("sobel_abs_r4", 32'(out_q[4*IW+3]), 32'd0);
        out_mode = 2'b00;
        run_frame("sobel_clamp");
        chk("sobel_clamp_r2", 32'(out_q[2*IW+3]), 32'd255);

        // Box kernel on constant 255: everything saturates, two frames
        set_box();
        for (int k = 0; k < NP; k++) pix[k] = 255;
        run_frame("box255_f1");
`ifdef CONV_SAT_COUNT_EN
        chk("sat_count_f1", 32'(sat_count), 32'd48);
`endif
        run_frame("box255_f2");
`ifdef CONV_SAT_COUNT_EN
        chk("sat_count_f2", 32'(sat_count), 32'd48);
`endif

        // Identity ramp under backpressure: toggling then random stalls
        set_identity(); out_mode = 2'b00;
        for (int k = 0; k < NP; k++) pix[k] = k;
        stall_mode = 1;
        run_frame("ident_toggle");
        stall_mode = 2;
        run_frame("ident_rand");

        // Random pixels, kernels and modes with random stalls
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) coef[i][j] = $urandom_range(0, 6) - 3;
            for (int k = 0; k < NP; k++) pix[k] = $urandom_range(0, 255);
            out_mode = 2'($urandom_range(0, 3));
            run_frame($sformatf("rand%0d", f));
        end

        // Abort a frame after pixel 20, then a clean frame must match the model
        stall_mode = 0; set_box(); out_mode = 2'b00;
        for (int k = 0; k < NP; k++) pix[k] = 200;
        send_pixels(21);
        do_reset();
        for (int k = 0; k < NP; k++) pix[k] = $urandom_range(0, 40);
        run_frame("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
